// File: rtl/breakout_video_pkg.sv
// Shared timing constants and count types for the Breakout video chain.
package breakout_video_pkg;

  typedef logic [8:0] hcount_t;
  typedef logic [8:0] vcount_t;

  localparam int H_TOTAL_DEF      = 454;
  localparam int HBLANK_START_DEF = 320;
  localparam int HSYNC_START_DEF  = 352;
  localparam int HSYNC_END_DEF    = 384;

  localparam int V_TOTAL_DEF      = 262;
  localparam int VBLANK_START_DEF = 224;
  localparam int VSYNC_START_DEF  = 232;
  localparam int VSYNC_END_DEF    = 236;

  localparam int COUNT_MAX        = 512;

endpackage

// File: rtl/video_timing_if.sv
// Pixel clock in, counts/blank/sync/pulses out. master = timing generator,
// slave = the clock block plus every downstream consumer of the counts.
interface video_timing_if;
  import breakout_video_pkg::*;

  logic    CLOCK;
  hcount_t HCOUNT;
  vcount_t VCOUNT;
  logic    HBLANK;
  logic    VBLANK;
  logic    HSYNC;
  logic    VSYNC;
  logic    COMP_SYNC_N;
  logic    PIX_TICK;
  logic    LINE_START;
  logic    FRAME_START;

  modport master (
    input  CLOCK,
    output HCOUNT, VCOUNT, HBLANK, VBLANK, HSYNC, VSYNC,
    output COMP_SYNC_N, PIX_TICK, LINE_START, FRAME_START
  );

  modport slave (
    output CLOCK,
    input  HCOUNT, VCOUNT, HBLANK, VBLANK, HSYNC, VSYNC,
    input  COMP_SYNC_N, PIX_TICK, LINE_START, FRAME_START
  );

endinterface

// File: rtl/video_timing_rise_detect.sv
// Rising-edge detector for a slow clock treated as data. History resets to 1
// so a signal already high at reset release does not produce a pulse.
module rise_detect (
  input  logic CLK_DRV,
  input  logic RESET,
  input  logic D,
  output logic PULSE
);

  logic d_q;

  // One-cycle history of D.
  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) d_q <= 1'b1;
    else       d_q <= D;
  end

  assign PULSE = D & ~d_q;

endmodule

// File: rtl/video_timing.sv
// Breakout horizontal/vertical counter chain driven by the divided pixel clock.
// All decodes are registered from the next-count values so blank/sync always
// line up with the counts shown in the same cycle.
module video_timing
  import breakout_video_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int HBLANK_START = HBLANK_START_DEF,
  parameter int HSYNC_START  = HSYNC_START_DEF,
  parameter int HSYNC_END    = HSYNC_END_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int VBLANK_START = VBLANK_START_DEF,
  parameter int VSYNC_START  = VSYNC_START_DEF,
  parameter int VSYNC_END    = VSYNC_END_DEF
) (
  input  logic               CLK_DRV,
  input  logic               RESET,
  video_timing_if.master     vt
);

  if (!(HSYNC_START < HSYNC_END && HSYNC_END <= H_TOTAL && HBLANK_START <= HSYNC_START))
    begin : g_bad_h_timing
      $error("video_timing: inconsistent horizontal timing parameters");
    end
  if (!(VSYNC_START < VSYNC_END && VSYNC_END <= V_TOTAL && VBLANK_START <= VSYNC_START))
    begin : g_bad_v_timing
      $error("video_timing: inconsistent vertical timing parameters");
    end
  if (H_TOTAL > COUNT_MAX || V_TOTAL > COUNT_MAX || H_TOTAL < 2 || V_TOTAL < 2)
    begin : g_bad_totals
      $error("video_timing: H_TOTAL/V_TOTAL must lie in 2..512");
    end

  localparam hcount_t H_LAST   = hcount_t'(H_TOTAL - 1);
  localparam hcount_t HBLANK_S = hcount_t'(HBLANK_START);
  localparam hcount_t HSYNC_S  = hcount_t'(HSYNC_START);
  localparam hcount_t HSYNC_E  = hcount_t'(HSYNC_END);
  localparam vcount_t V_LAST   = vcount_t'(V_TOTAL - 1);
  localparam vcount_t VBLANK_S = vcount_t'(VBLANK_START);
  localparam vcount_t VSYNC_S  = vcount_t'(VSYNC_START);
  localparam vcount_t VSYNC_E  = vcount_t'(VSYNC_END);

  logic    tick;
  hcount_t hcount_q, hcount_nxt;
  vcount_t vcount_q, vcount_nxt;
  logic    line_wrap, frame_wrap;
  logic    hblank_nxt, hsync_nxt, vblank_nxt, vsync_nxt;
  logic    hblank_q, hsync_q, vblank_q, vsync_q, comp_sync_n_q;
  logic    pix_tick_q, line_start_q, frame_start_q;

  rise_detect u_clock_rise (
    .CLK_DRV (CLK_DRV),
    .RESET   (RESET),
    .D       (vt.CLOCK),
    .PULSE   (tick)
  );

  // Next counts; >= on the wrap compare also recovers any out-of-range value.
  always_comb begin
    line_wrap  = (hcount_q >= H_LAST);
    frame_wrap = line_wrap && (vcount_q >= V_LAST);
    hcount_nxt = line_wrap ? '0 : hcount_q + 9'd1;
    vcount_nxt = vcount_q;
    if (line_wrap) begin
      vcount_nxt = (vcount_q >= V_LAST) ? '0 : vcount_q + 9'd1;
    end
  end

  // Blank/sync decode of the next counts.
  always_comb begin
    hblank_nxt = (hcount_nxt >= HBLANK_S);
    hsync_nxt  = (hcount_nxt >= HSYNC_S) && (hcount_nxt < HSYNC_E);
    vblank_nxt = (vcount_nxt >= VBLANK_S);
    vsync_nxt  = (vcount_nxt >= VSYNC_S) && (vcount_nxt < VSYNC_E);
  end

  // Counts and levels advance only on a pixel tick; pulses follow the tick.
  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hblank_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vblank_q      <= 1'b0;
      vsync_q       <= 1'b0;
      comp_sync_n_q <= 1'b1;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_tick_q    <= tick;
      line_start_q  <= tick & line_wrap;
      frame_start_q <= tick & frame_wrap;
      if (tick) begin
        hcount_q      <= hcount_nxt;
        vcount_q      <= vcount_nxt;
        hblank_q      <= hblank_nxt;
        hsync_q       <= hsync_nxt;
        vblank_q      <= vblank_nxt;
        vsync_q       <= vsync_nxt;
        comp_sync_n_q <= ~(hsync_nxt ^ vsync_nxt);
      end
    end
  end

  assign vt.HCOUNT      = hcount_q;
  assign vt.VCOUNT      = vcount_q;
  assign vt.HBLANK      = hblank_q;
  assign vt.HSYNC       = hsync_q;
  assign vt.VBLANK      = vblank_q;
  assign vt.VSYNC       = vsync_q;
  assign vt.COMP_SYNC_N = comp_sync_n_q;
  assign vt.PIX_TICK    = pix_tick_q;
  assign vt.LINE_START  = line_start_q;
  assign vt.FRAME_START = frame_start_q;

endmodule

// File: tb/tb_video_timing.sv
// Directed bench: dut_a runs the default Breakout timing, dut_b a scaled-down
// timing (20 x 16) so a whole frame, including the frame wrap, fits in a short run.
module tb_video_timing;

  logic clk_drv;
  logic rst;
  int   n_checks;
  int   n_errors;

  video_timing_if vif_a ();
  video_timing_if vif_b ();

  video_timing dut_a (
    .CLK_DRV (clk_drv),
    .RESET   (rst),
    .vt      (vif_a)
  );

  video_timing #(
    .H_TOTAL      (20),
    .HBLANK_START (12),
    .HSYNC_START  (14),
    .HSYNC_END    (16),
    .V_TOTAL      (16),
    .VBLANK_START (10),
    .VSYNC_START  (12),
    .VSYNC_END    (14)
  ) dut_b (
    .CLK_DRV (clk_drv),
    .RESET   (rst),
    .vt      (vif_b)
  );

  initial begin
    clk_drv = 1'b0;
    forever #5 clk_drv = ~clk_drv;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive CLOCK of one DUT, then step to just after the next CLK_DRV edge.
  task automatic clk_level(input bit sel_b, input logic lvl);
    if (sel_b) vif_b.CLOCK = lvl;
    else       vif_a.CLOCK = lvl;
    @(posedge clk_drv);
    #1;
  endtask

  task automatic tick_a();
    clk_level(1'b0, 1'b1);
    clk_level(1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int eh, ev, hb_first, hs_first, hs_last, hs_cnt, vs_cnt, ls_cnt, fs_cnt;
    int n_pulse, bad;
    logic exp_hs, exp_vs, line, frame;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    vif_a.CLOCK = 1'b0;
    vif_b.CLOCK = 1'b0;
    repeat (3) @(posedge clk_drv);
    #1;

    check_val("rst_hcount", vif_a.HCOUNT, 0);
    check_val("rst_vcount", vif_a.VCOUNT, 0);
    check_val("rst_levels", {vif_a.HBLANK, vif_a.HSYNC, vif_a.VBLANK, vif_a.VSYNC}, 0);
    check_val("rst_comp_sync_n", vif_a.COMP_SYNC_N, 1);
    check_val("rst_pulses", {vif_a.PIX_TICK, vif_a.LINE_START, vif_a.FRAME_START}, 0);
    check_val("rst_b_comp_sync_n", vif_b.COMP_SYNC_N, 1);

    rst = 1'b0;
    @(posedge clk_drv);
    #1;

    // Whole frame on the small DUT.
    eh = 0; ev = 0; hs_cnt = 0; vs_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 320; i++) begin
      clk_level(1'b1, 1'b1);
      line  = (eh == 19);
      frame = line && (ev == 15);
      if (line) begin
        eh = 0;
        ev = (ev == 15) ? 0 : ev + 1;
      end else begin
        eh = eh + 1;
      end
      exp_hs = (eh >= 14) && (eh < 16);
      exp_vs = (ev >= 12) && (ev < 14);
      check_val("b_hcount", vif_b.HCOUNT, eh);
      check_val("b_vcount", vif_b.VCOUNT, ev);
      check_val("b_hblank", vif_b.HBLANK, (eh >= 12));
      check_val("b_hsync", vif_b.HSYNC, exp_hs);
      check_val("b_vblank", vif_b.VBLANK, (ev >= 10));
      check_val("b_vsync", vif_b.VSYNC, exp_vs);
      check_val("b_comp_sync_n", vif_b.COMP_SYNC_N, !(exp_hs ^ exp_vs));
      check_val("b_pix_tick", vif_b.PIX_TICK, 1);
      check_val("b_line_start", vif_b.LINE_START, line);
      check_val("b_frame_start", vif_b.FRAME_START, frame);
      if (vif_b.HSYNC) hs_cnt++;
      if (vif_b.VSYNC) vs_cnt++;
      if (vif_b.LINE_START) ls_cnt++;
      if (vif_b.FRAME_START) fs_cnt++;
      clk_level(1'b1, 1'b0);
      check_val("b_pulses_low", {vif_b.PIX_TICK, vif_b.LINE_START, vif_b.FRAME_START}, 0);
    end
    check_val("b_frame_hcount", vif_b.HCOUNT, 0);
    check_val("b_frame_vcount", vif_b.VCOUNT, 0);
    check_val("b_hsync_ticks", hs_cnt, 32);
    check_val("b_vsync_ticks", vs_cnt, 40);
    check_val("b_line_starts", ls_cnt, 16);
    check_val("b_frame_starts", fs_cnt, 1);

    // CLOCK 7 high / 7 low on the default DUT: one tick per 14 cycles.
    n_pulse = 0; bad = 0;
    for (int c = 0; c < 42; c++) begin
      vif_a.CLOCK = ((c % 14) < 7);
      @(posedge clk_drv);
      #1;
      if (c == 0) begin
        check_val("a_first_tick", vif_a.PIX_TICK, 1);
        check_val("a_first_hcount", vif_a.HCOUNT, 1);
      end
      if (vif_a.PIX_TICK) begin
        n_pulse++;
        if ((c % 14) != 0) bad++;
      end
    end
    check_val("a_tick_count", n_pulse, 3);
    check_val("a_tick_spacing", bad, 0);
    check_val("a_hcount_after_ticks", vif_a.HCOUNT, 3);

    // Sweep the rest of line 0 on the default timing.
    eh = 3; hb_first = -1; hs_first = -1; hs_last = -1; hs_cnt = 0;
    while (eh < 453) begin
      clk_level(1'b0, 1'b1);
      eh = eh + 1;
      exp_hs = (eh >= 352) && (eh < 384);
      check_val("a_hcount", vif_a.HCOUNT, eh);
      check_val("a_hblank", vif_a.HBLANK, (eh >= 320));
      check_val("a_hsync", vif_a.HSYNC, exp_hs);
      check_val("a_comp_sync_n", vif_a.COMP_SYNC_N, !exp_hs);
      if (vif_a.HBLANK && hb_first < 0) hb_first = vif_a.HCOUNT;
      if (vif_a.HSYNC) begin
        if (hs_first < 0) hs_first = vif_a.HCOUNT;
        hs_last = vif_a.HCOUNT;
        hs_cnt++;
      end
      clk_level(1'b0, 1'b0);
    end
    check_val("a_hblank_first", hb_first, 320);
    check_val("a_hsync_first", hs_first, 352);
    check_val("a_hsync_last", hs_last, 383);
    check_val("a_hsync_ticks", hs_cnt, 32);

    // Advance to HCOUNT=453 of line 10, then wrap to line 11.
    for (int i = 0; i < 5000; i++) begin
      if (vif_a.HCOUNT == 453 && vif_a.VCOUNT == 10) break;
      tick_a();
    end
    check_val("a_reach_h453", vif_a.HCOUNT, 453);
    check_val("a_reach_v10", vif_a.VCOUNT, 10);
    clk_level(1'b0, 1'b1);
    check_val("a_wrap_hcount", vif_a.HCOUNT, 0);
    check_val("a_wrap_vcount", vif_a.VCOUNT, 11);
    check_val("a_wrap_line_start", vif_a.LINE_START, 1);
    check_val("a_wrap_frame_start", vif_a.FRAME_START, 0);
    check_val("a_wrap_hblank", vif_a.HBLANK, 0);
    clk_level(1'b0, 1'b0);

    // Freeze at HCOUNT=200 with CLOCK held high.
    repeat (199) tick_a();
    clk_level(1'b0, 1'b1);
    check_val("a_hold_start", vif_a.HCOUNT, 200);
    bad = 0;
    repeat (100) begin
      clk_level(1'b0, 1'b1);
      if (vif_a.HCOUNT != 200 || vif_a.VCOUNT != 11 || vif_a.PIX_TICK ||
          vif_a.LINE_START || vif_a.FRAME_START || vif_a.HBLANK || vif_a.HSYNC ||
          vif_a.VBLANK || vif_a.VSYNC || !vif_a.COMP_SYNC_N) bad++;
    end
    check_val("a_hold_frozen", bad, 0);
    check_val("a_hold_hcount", vif_a.HCOUNT, 200);
    clk_level(1'b0, 1'b0);

    // Mid-line reset inside HSYNC with CLOCK high.
    repeat (159) tick_a();
    clk_level(1'b0, 1'b1);
    check_val("a_pre_rst_hcount", vif_a.HCOUNT, 360);
    check_val("a_pre_rst_hsync", vif_a.HSYNC, 1);
    check_val("a_pre_rst_comp_sync_n", vif_a.COMP_SYNC_N, 0);
    rst = 1'b1;
    #1;
    check_val("a_rst_hcount", vif_a.HCOUNT, 0);
    check_val("a_rst_vcount", vif_a.VCOUNT, 0);
    check_val("a_rst_levels", {vif_a.HBLANK, vif_a.HSYNC, vif_a.VBLANK, vif_a.VSYNC}, 0);
    check_val("a_rst_comp_sync_n", vif_a.COMP_SYNC_N, 1);
    repeat (3) @(posedge clk_drv);
    #1;
    rst = 1'b0;
    bad = 0;
    repeat (5) begin
      clk_level(1'b0, 1'b1);
      if (vif_a.PIX_TICK || vif_a.HCOUNT != 0) bad++;
    end
    check_val("a_no_tick_after_rst", bad, 0);
    clk_level(1'b0, 1'b0);
    clk_level(1'b0, 1'b1);
    check_val("a_post_rst_tick", vif_a.PIX_TICK, 1);
    check_val("a_post_rst_hcount", vif_a.HCOUNT, 1);
    check_val("a_post_rst_vcount", vif_a.VCOUNT, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/video_timing.md
Name: video_timing

Overview:
- Consumes the divided pixel clock (CLOCK) produced by the clock block and turns it into the Breakout horizontal/vertical counter chain.
- Outputs: H/V counts, blanking, sync and a composite sync for the video output stage.
- Runs entirely in the CLK_DRV domain. CLOCK is treated as a data signal and rising-edge detected into a one-cycle pixel tick.
- Every game-logic block downstream keys off these counts.

Parameters:
- H_TOTAL, 454, pixel ticks per line; HCOUNT runs 0..H_TOTAL-1.
- HBLANK_START, 320, first HCOUNT with HBLANK=1 (blank through H_TOTAL-1).
- HSYNC_START, 352, first HCOUNT with HSYNC=1.
- HSYNC_END, 384, first HCOUNT with HSYNC=0 again.
- V_TOTAL, 262, lines per frame; VCOUNT runs 0..V_TOTAL-1.
- VBLANK_START, 224, first VCOUNT with VBLANK=1.
- VSYNC_START, 232, first VCOUNT with VSYNC=1.
- VSYNC_END, 236, first VCOUNT with VSYNC=0 again.

Ports:
- CLK_DRV  in  1  system clock; all flops on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CLOCK  in  1  divided pixel clock from the clock block, synchronous to CLK_DRV.
- HCOUNT  out  9  horizontal pixel count.
- VCOUNT  out  9  vertical line count.
- HBLANK  out  1  horizontal blank.
- VBLANK  out  1  vertical blank.
- HSYNC  out  1  horizontal sync, active high.
- VSYNC  out  1  vertical sync, active high.
- COMP_SYNC_N  out  1  composite sync, active low; equals ~(HSYNC ^ VSYNC).
- PIX_TICK  out  1  one-CLK_DRV pulse per pixel.
- LINE_START  out  1  pulse coincident with the tick that sets HCOUNT to 0.
- FRAME_START  out  1  pulse coincident with the tick that sets HCOUNT=0 and VCOUNT=0.

Behaviour:
- Reset values (asynchronous, while RESET=1):
  - HCOUNT=0, VCOUNT=0.
  - HBLANK=HSYNC=VBLANK=VSYNC=0, COMP_SYNC_N=1.
  - PIX_TICK=LINE_START=FRAME_START=0.
  - CLOCK history flop=1, so no spurious tick on the first cycle after release.
- Tick generation:
  - Internal tick = CLOCK & ~clock_q, where clock_q is CLOCK delayed one CLK_DRV cycle.
  - PIX_TICK is the tick registered, so it is high in the same cycle the counters show the new value.
  - Latency: CLOCK rising at cycle n -> new counts and PIX_TICK visible in cycle n+1.
- Counting, on each tick:
  - If HCOUNT==H_TOTAL-1: HCOUNT<=0 and VCOUNT advances; otherwise HCOUNT<=HCOUNT+1.
  - VCOUNT advances only on the HCOUNT wrap: if VCOUNT==V_TOTAL-1 then VCOUNT<=0, else VCOUNT+1.
  - Without a tick, all counts and levels hold. PIX_TICK, LINE_START and FRAME_START drop to 0.
- Decode: HBLANK, HSYNC, VBLANK and VSYNC are registered from the next-count values, so they are always coherent with the displayed counts.
  - HBLANK = HCOUNT >= HBLANK_START.
  - HSYNC = HSYNC_START <= HCOUNT < HSYNC_END.
  - VBLANK = VCOUNT >= VBLANK_START.
  - VSYNC = VSYNC_START <= VCOUNT < VSYNC_END.
- Width rules:
  - Counts are 9 bit unsigned.
  - Compares are unsigned. Increment carries never escape, because the wrap compare precedes the increment.
- Boundary conditions:
  - Out-of-range counts (unreachable after reset) wrap to 0 on the next tick via the >= H_TOTAL-1 / >= V_TOTAL-1 compare.
  - CLOCK stuck high or low: no ticks, outputs hold.
  - RESET asserted mid-line: immediate return to reset values. After release, the first CLOCK rising edge produces HCOUNT=1.
  - Tick at HCOUNT=H_TOTAL-1 and VCOUNT=V_TOTAL-1: both wrap in the same cycle, LINE_START=FRAME_START=1.
- Parameter checks (elaboration-time assertions):
  - Horizontal: HSYNC_START < HSYNC_END <= H_TOTAL and HBLANK_START <= HSYNC_START.
  - Vertical: VSYNC_START < VSYNC_END <= V_TOTAL and VBLANK_START <= VSYNC_START.
  - H_TOTAL and V_TOTAL must each be <= 512.

Decomposition:
- Package breakout_video_pkg:
  - Default timing constants.
  - Typedef hcount_t = logic [8:0], vcount_t = logic [8:0].
- One sub-module: rise_detect, with CLK_DRV, RESET, D, PULSE and reset history 1. It is reused for CKBH elsewhere.

Test Plan:
- CLOCK toggling 7 high/7 low after reset release -> first PIX_TICK one cycle after the first CLOCK rise, HCOUNT=1; exactly one PIX_TICK per 14 CLK_DRV cycles.
- Run to HCOUNT=453 at VCOUNT=10, then one tick -> HCOUNT=0, VCOUNT=11, LINE_START=1, FRAME_START=0.
- Run to HCOUNT=453 at VCOUNT=261, then one tick -> HCOUNT=0, VCOUNT=0, LINE_START=FRAME_START=1.
- Sweep one full frame:
  - HBLANK rises at HCOUNT=320; HSYNC is high for HCOUNT 352..383 (32 ticks).
  - VBLANK rises at VCOUNT=224; VSYNC is high for lines 232..235.
  - COMP_SYNC_N=0 exactly when HSYNC xor VSYNC.
- Hold CLOCK constant for 100 cycles mid-line at HCOUNT=200 -> all outputs frozen, no pulses.
- Assert RESET at HCOUNT=300, VCOUNT=100 for 3 cycles with CLOCK=1 -> all outputs at reset values immediately. After release with CLOCK still 1: no tick until the next 0->1 transition.
